// File: rtl/hilo_unit.sv
// HI/LO register pair with a 32-cycle shift-add multiplier and a start/busy
// sequencer for the external negedge divider. Define HILO_DIV0_BYPASS_EN to skip the divider on a zero divisor.
module hilo_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {IDLE, MUL, MFIX, DLAUNCH, DWAIT, DWRITE} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_mcand, r_acc;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_neg, r_seen;
  logic [31:0] r_hi, r_lo, r_div_dividend, r_div_divisor;
  logic        r_stall, r_op_err, r_div_start;
  logic [31:0] w_rs_abs, w_rt_abs;
  logic        w_illegal, w_div0;

  assign w_rs_abs  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign w_rt_abs  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign w_illegal = !(op inside {OP_MULT, OP_MULTU, OP_DIV, OP_MTHI, OP_MTLO});

`ifdef HILO_DIV0_BYPASS_EN
  logic r_byp;
  assign w_div0 = (rt_val == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          if (op == OP_MULT || op == OP_MULTU) w_next = MUL;
          else if (op == OP_DIV)               w_next = w_div0 ? DWRITE : DLAUNCH;
        end
      end
      MUL:     if (r_cnt == 5'd31) w_next = MFIX;
      MFIX:    w_next = IDLE;
      DLAUNCH: w_next = DWAIT;
      // seen guards against leaving before the divider has raised busy
      DWAIT:   if (r_seen && !div_busy) w_next = DWRITE;
      DWRITE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand        <= '0;
      r_acc          <= '0;
      r_mplier       <= '0;
      r_cnt          <= '0;
      r_neg          <= 1'b0;
      r_seen         <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_stall        <= 1'b0;
      r_op_err       <= 1'b0;
      r_div_start    <= 1'b0;
`ifdef HILO_DIV0_BYPASS_EN
      r_byp          <= 1'b0;
`endif
    end else begin
      r_op_err    <= (r_state == IDLE) && op_valid && w_illegal;
      r_div_start <= (w_next == DLAUNCH);
      r_stall     <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULT: begin
                r_mcand  <= {32'd0, w_rs_abs};
                r_mplier <= w_rt_abs;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= rs_val[31] ^ rt_val[31];
              end
              OP_MULTU: begin
                r_mcand  <= {32'd0, rs_val};
                r_mplier <= rt_val;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= 1'b0;
              end
              OP_DIV: begin
                r_div_dividend <= rs_val;
                r_div_divisor  <= rt_val;
                r_seen         <= 1'b0;
`ifdef HILO_DIV0_BYPASS_EN
                r_byp          <= w_div0;
`endif
              end
              OP_MTHI: r_hi <= rs_val;
              OP_MTLO: r_lo <= rs_val;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        MFIX: {r_hi, r_lo} <= r_neg ? (~r_acc + 64'd1) : r_acc;
        DWAIT: if (div_busy) r_seen <= 1'b1;
        DWRITE: begin
`ifdef HILO_DIV0_BYPASS_EN
          if (r_byp) begin
            r_hi <= r_div_dividend;
            r_lo <= '1;
          end else begin
            r_hi <= div_r;
            r_lo <= div_q;
          end
`else
          r_hi <= div_r;
          r_lo <= div_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign stall        = r_stall;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign op_err       = r_op_err;
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;

endmodule
